// File: rtl/updown_count_controller_pkg.sv
// updown_ctrl_pkg: shared state encoding and counter mode constants for the up/down count controller.
package updown_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} state_t;
    localparam logic MODE_UP = 1'b0;
    localparam logic MODE_DOWN = 1'b1;
endpackage

// File: rtl/updown_count_controller_if.sv
// updown_count_controller_if: control/feedback bundle between a stimulus master and the controller.
interface updown_count_controller_if #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8
);
    logic             start;
    logic             stop;
    logic             dir_req;
    logic             bounce_en;
    logic [WIDTH-1:0] low_lim;
    logic [WIDTH-1:0] high_lim;
    logic [WIDTH-1:0] count_in;
    logic             cnt_en;
    logic             cnt_mode;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [REV_W-1:0] rev_count;
    modport master (
        output start, stop, dir_req, bounce_en, low_lim, high_lim, count_in,
        input  cnt_en, cnt_mode, busy, done, cfg_err, rev_count
    );
    modport slave (
        input  start, stop, dir_req, bounce_en, low_lim, high_lim, count_in,
        output cnt_en, cnt_mode, busy, done, cfg_err, rev_count
    );
endinterface

// File: rtl/updown_count_controller_limit_cmp.sv
// updown_limit_cmp: combinational compare of the counter value against the programmed limits.
module updown_limit_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_low,
    input  logic [WIDTH-1:0] i_high,
    output logic             o_at_low,
    output logic             o_at_high,
    output logic             o_in_range
);
    assign o_at_low   = i_count == i_low;
    assign o_at_high  = i_count == i_high;
    // An empty or inverted window counts as out of range.
    assign o_in_range = (i_low < i_high) && (i_count >= i_low) && (i_count <= i_high);
endmodule

// File: rtl/updown_count_controller.sv
// updown_count_controller: drives enable/mode of an up/down counter between limits, one-shot or bounce.
// Define UPDOWN_REV_COUNT_EN to build the saturating bounce-reversal counter on rev_count.
module updown_count_controller
    import updown_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REV_W = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    updown_count_controller_if.slave ifc
);
    state_t r_state;
    logic   r_en, r_mode, r_busy, r_done, r_cfg_err;
    logic   w_at_low, w_at_high, w_in_range, w_start_lim;

    updown_limit_cmp #(.WIDTH(WIDTH)) u_cmp (
        .i_count    (ifc.count_in),
        .i_low      (ifc.low_lim),
        .i_high     (ifc.high_lim),
        .o_at_low   (w_at_low),
        .o_at_high  (w_at_high),
        .o_in_range (w_in_range)
    );

    // Counter already sits on the limit it was asked to head towards.
    assign w_start_lim = ifc.dir_req ? w_at_low : w_at_high;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_mode    <= MODE_UP;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (ifc.stop) begin
                r_state <= IDLE;
                r_en    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (ifc.start) begin
                        if (!w_in_range) r_cfg_err <= 1'b1;
                        else if (w_start_lim && !ifc.bounce_en) r_done <= 1'b1;
                        else begin
                            r_state <= (ifc.dir_req ^ w_start_lim) ? RUN_DOWN : RUN_UP;
                            r_mode  <= ifc.dir_req ^ w_start_lim;
                            r_en    <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    RUN_UP: if (w_at_high) begin
                        if (ifc.bounce_en) begin
                            r_state <= RUN_DOWN;
                            r_mode  <= MODE_DOWN;
                        end else begin
                            r_state <= IDLE;
                            r_en    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    RUN_DOWN: if (w_at_low) begin
                        if (ifc.bounce_en) begin
                            r_state <= RUN_UP;
                            r_mode  <= MODE_UP;
                        end else begin
                            r_state <= IDLE;
                            r_en    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign ifc.cnt_en   = r_en;
    assign ifc.cnt_mode = r_mode;
    assign ifc.busy     = r_busy;
    assign ifc.done     = r_done;
    assign ifc.cfg_err  = r_cfg_err;

`ifdef UPDOWN_REV_COUNT_EN
    logic [REV_W-1:0] r_rev;
    logic             w_accept, w_reverse;
    assign w_accept  = (r_state == IDLE) && ifc.start && !ifc.stop && w_in_range;
    // A bounce start on the limit turns around immediately and counts as a reversal.
    assign w_reverse = !ifc.stop && ifc.bounce_en &&
                       (((r_state == RUN_UP) && w_at_high) || ((r_state == RUN_DOWN) && w_at_low) ||
                        (w_accept && w_start_lim));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rev <= '0;
        else if (w_accept) r_rev <= REV_W'(w_reverse);
        else if (w_reverse && !(&r_rev)) r_rev <= r_rev + 1'b1;
    end
    assign ifc.rev_count = r_rev;
`else
    assign ifc.rev_count = {REV_W{1'b0}};
`endif
endmodule

// File: tb/tb_updown_count_controller.sv
// tb_updown_count_controller: scoreboard bench; a negedge counter model closes the loop on count_in.
module tb_updown_count_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    updown_count_controller_if #(.WIDTH(4), .REV_W(8)) ifc ();
    updown_count_controller #(.WIDTH(4), .REV_W(8)) dut (.clk(clk), .rst_n(rst_n), .ifc(ifc));

    typedef struct packed {
        logic busy, en, mode, done, cfg;
        logic [3:0] cnt;
        logic [7:0] rev;
    } snap_t;

    snap_t exp_q[$];
    string name_q[$];
    snap_t prev;
    int total = 0;
    int bad = 0;

    function automatic logic [7:0] rv(input int r);
`ifdef UPDOWN_REV_COUNT_EN
        return 8'(r);
`else
        return 8'(r * 0);
`endif
    endfunction

    function automatic snap_t cur();
        return {ifc.busy, ifc.cnt_en, ifc.cnt_mode, ifc.done, ifc.cfg_err, ifc.count_in, ifc.rev_count};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("busy=%0b en=%0b mode=%0b done=%0b cfg_err=%0b cnt=%0d rev=%0d",
                         s.busy, s.en, s.mode, s.done, s.cfg, s.cnt, s.rev);
    endfunction

    task automatic expect_ev(input string n, input logic b, e, m, d, c, input int cnt, input int r);
        exp_q.push_back({b, e, m, d, c, 4'(cnt), rv(r)});
        name_q.push_back(n);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", n, act, req);
        end
    endtask

    // Counter under control: counts on the negedge after the controller's posedge decision.
    always @(negedge clk) if (ifc.cnt_en) ifc.count_in = ifc.cnt_mode ? ifc.count_in - 4'd1 : ifc.count_in + 4'd1;

    // Any change of the observed outputs/count is a DUT event matched against the scoreboard.
    always @(posedge clk) begin : mon
        snap_t a, x;
        string n;
        #1;
        a = cur();
        if (rst_n && a != prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got %s", fmt(a));
            end else begin
                x = exp_q.pop_front();
                n = name_q.pop_front();
                if (a !== x) begin
                    bad++;
                    $display("FAIL %s got %s expected %s", n, fmt(a), fmt(x));
                end
            end
        end
        prev = a;
    end

    task automatic go(input int lo, input int hi, input int c, input logic dir, input logic bnc, input logic stp);
        @(negedge clk);
        #1;
        ifc.low_lim = 4'(lo);
        ifc.high_lim = 4'(hi);
        ifc.count_in = 4'(c);
        ifc.dir_req = dir;
        ifc.bounce_en = bnc;
        ifc.stop = stp;
        ifc.start = 1'b1;
        @(negedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.stop = 1'b0;
    endtask

    task automatic stop_after(input int k);
        repeat (k) @(negedge clk);
        #1 ifc.stop = 1'b1;
        @(negedge clk);
        #1 ifc.stop = 1'b0;
    endtask

    task automatic drain(input string n);
        int k = 0;
        while (exp_q.size() > 0 && k < 40) begin
            @(posedge clk);
            #2;
            k++;
        end
        total++;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL %s_timeout got=%0d pending expected=0", n, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.stop = 1'b0;
        ifc.dir_req = 1'b0;
        ifc.bounce_en = 1'b0;
        ifc.low_lim = '0;
        ifc.high_lim = '0;
        ifc.count_in = '0;
        #1 rst_n = 1'b0;
        #11;
        chk("reset_busy", 32'(ifc.busy), 0);
        chk("reset_cnt_en", 32'(ifc.cnt_en), 0);
        chk("reset_mode", 32'(ifc.cnt_mode), 0);
        chk("reset_done", 32'(ifc.done), 0);
        chk("reset_cfg_err", 32'(ifc.cfg_err), 0);
        chk("reset_rev", 32'(ifc.rev_count), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        expect_ev("oneshot_start", 1, 1, 0, 0, 0, 2, 0);
        expect_ev("oneshot_c3",    1, 1, 0, 0, 0, 3, 0);
        expect_ev("oneshot_c4",    1, 1, 0, 0, 0, 4, 0);
        expect_ev("oneshot_done",  0, 0, 0, 1, 0, 5, 0);
        expect_ev("oneshot_idle",  0, 0, 0, 0, 0, 5, 0);
        go(2, 5, 2, 0, 0, 0);
        drain("oneshot");

        expect_ev("bounce_c1",     1, 1, 0, 0, 0, 1, 0);
        expect_ev("bounce_c2",     1, 1, 0, 0, 0, 2, 0);
        expect_ev("bounce_c3",     1, 1, 0, 0, 0, 3, 0);
        expect_ev("bounce_rev_hi", 1, 1, 1, 0, 0, 4, 1);
        expect_ev("bounce_d3",     1, 1, 1, 0, 0, 3, 1);
        expect_ev("bounce_d2",     1, 1, 1, 0, 0, 2, 1);
        expect_ev("bounce_rev_lo", 1, 1, 0, 0, 0, 1, 2);
        expect_ev("bounce_stop",   0, 0, 0, 0, 0, 2, 2);
        go(1, 4, 1, 0, 1, 0);
        stop_after(6);
        drain("bounce");

        expect_ev("cfg_inverted",     0, 0, 0, 0, 1, 4, 2);
        expect_ev("cfg_inverted_end", 0, 0, 0, 0, 0, 4, 2);
        go(6, 3, 4, 0, 0, 0);
        drain("cfg_inverted");
        expect_ev("cfg_outside",     0, 0, 0, 0, 1, 9, 2);
        expect_ev("cfg_outside_end", 0, 0, 0, 0, 0, 9, 2);
        go(2, 5, 9, 0, 0, 0);
        drain("cfg_outside");

        expect_ev("stop_down_start", 1, 1, 1, 0, 0, 5, 0);
        expect_ev("stop_down_c4",    1, 1, 1, 0, 0, 4, 0);
        expect_ev("stop_down_c3",    1, 1, 1, 0, 0, 3, 0);
        expect_ev("stop_at_low",     0, 0, 1, 0, 0, 2, 0);
        go(2, 6, 5, 1, 0, 0);
        stop_after(2);
        drain("stop_prio");
        go(2, 6, 2, 0, 0, 1);
        repeat (3) @(negedge clk);
        chk("start_stop_busy", 32'(ifc.busy), 0);
        chk("start_stop_cnt_en", 32'(ifc.cnt_en), 0);

        expect_ev("limit_bounce_start", 1, 1, 1, 0, 0, 7, 1);
        expect_ev("limit_bounce_c6",    1, 1, 1, 0, 0, 6, 1);
        expect_ev("limit_bounce_stop",  0, 0, 1, 0, 0, 5, 1);
        go(3, 7, 7, 0, 1, 0);
        stop_after(1);
        drain("limit_bounce");

        expect_ev("limit_oneshot_done", 0, 0, 1, 1, 0, 7, 0);
        expect_ev("limit_oneshot_end",  0, 0, 1, 0, 0, 7, 0);
        go(3, 7, 7, 0, 0, 0);
        drain("limit_oneshot");

        expect_ev("rst_run_start", 1, 1, 0, 0, 0, 0, 0);
        expect_ev("rst_run_c1",    1, 1, 0, 0, 0, 1, 0);
        go(0, 15, 0, 0, 1, 0);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 32'(ifc.busy), 0);
        chk("midrun_rst_cnt_en", 32'(ifc.cnt_en), 0);
        chk("midrun_rst_mode", 32'(ifc.cnt_mode), 0);
        chk("midrun_rst_done", 32'(ifc.done), 0);
        chk("midrun_rst_rev", 32'(ifc.rev_count), 0);
        chk("midrun_rst_pending", 32'(exp_q.size()), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("after_rst_count", 32'(ifc.count_in), 2);
        chk("final_pending", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
